id_issue_ctrl: RTL
==================

Name: id_issue_ctrl

Overview:
- ID-stage pipeline register and issue controller, directly downstream of the IF stage and the consumer of the wake-up unit's src_1_ready/src_2_ready.
- Latches IF→ID payload under the valid/allowin handshake.
- Holds the instruction while an operand is not bypassable, and issues it to EXE when both operands are ready and EXE accepts.
- Provides a stall-cycle counter and a stall watchdog flag for debug/perf.

Parameters:
- BUS_WD, 64, width of IF→ID payload (PC[63:32], inst[31:0]), passed unchanged to EXE.
- CNT_WD, 32, width of the stall statistics counter.
- TIMEOUT, 1024, consecutive stall cycles that raise stall_timeout (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- IF_to_ID_valid  in  1  IF holds a valid instruction.
- IF_to_ID_bus  in  BUS_WD  IF payload.
- ID_allowin  out  1  ID can accept IF payload this cycle.
- ID_bus  out  BUS_WD  registered payload, feeds the decoder and wake-up (register numbers, sel_alu_src).
- src_1_ready  in  1  from wake-up, operand 1 obtainable.
- src_2_ready  in  1  from wake-up, operand 2 obtainable.
- EXE_allowin  in  1  EXE can accept.
- ID_to_EXE_valid  out  1  issue valid.
- ID_to_EXE_bus  out  BUS_WD  equals ID_bus.
- br_flush  in  1  redirect from EXE; kill the ID instruction.
- stall_cnt  out  CNT_WD  total operand-stall cycles since reset.
- stall_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (async, resetn=0):
  - ID_valid=0, ID_bus=0, state=S_EMPTY.
  - stall_cnt=0, consec counter=0, stall_timeout=0.
  - Outputs follow immediately: ID_allowin=1, ID_to_EXE_valid=0.
- Combinational signals:
  - ready_go = src_1_ready & src_2_ready.
  - ID_allowin = !ID_valid | (ready_go & EXE_allowin).
  - ID_to_EXE_valid = ID_valid & ready_go & !br_flush.
  - ID_to_EXE_bus = ID_bus.
- ID_valid update, priority order at the clock edge:
  - br_flush → 0.
  - else ID_allowin → IF_to_ID_valid.
  - else hold.
- ID_bus loads IF_to_ID_bus only when ID_allowin & IF_to_ID_valid & !br_flush; otherwise it holds. Contents are undefined-but-stable when ID_valid=0.
- FSM, registered, 2 bits, for observability and counters:
  - S_EMPTY: ID_valid=0.
  - S_WAIT: valid and !ready_go.
  - S_BLOCK: valid, ready_go, !EXE_allowin.
  - S_ISSUE: valid and issuing.
  - Next state is computed from the post-edge ID_valid and the current-cycle ready inputs.
  - br_flush from any state → S_EMPTY.
- Latency:
  - IF payload accepted at edge N appears on ID_bus in cycle N+1.
  - Issue happens in the same cycle ready_go & EXE_allowin are seen, so the minimum ID residency is 1 cycle.
- Back-to-back flow: an issue and a new accept in the same edge is required; full throughput is 1 instruction/cycle with no bubble.
- Stall counting:
  - stall_cnt increments by 1 on each edge where ID_valid & !ready_go & !br_flush.
  - It wraps modulo 2^CNT_WD.
  - EXE backpressure (S_BLOCK) is not counted.
- Watchdog:
  - The consecutive counter increments under the same condition as stall_cnt.
  - It clears on any edge where that condition is false.
  - It saturates at TIMEOUT.
  - stall_timeout sets when the counter reaches TIMEOUT and stays set until reset.
- Simultaneous events:
  - br_flush with IF_to_ID_valid=1 and ID_allowin=1: the flush wins; nothing is latched.
  - br_flush while in S_WAIT: the stall is not counted that cycle.
- src_*_ready inputs are ignored when ID_valid=0.
- Reset mid-stall: all state clears asynchronously, and ID_to_EXE_valid drops in the same cycle.

Decomposition:
- Shared header (myCPU.h):
  - IF_TO_ID_BUS_WD and ID_TO_EXE_BUS_WD width macros.
  - ID FSM state encodings (S_EMPTY=2'b00, S_WAIT=2'b01, S_BLOCK=2'b10, S_ISSUE=2'b11).
- One sub-module: stall_monitor. It contains the stall_cnt counter, the consecutive counter and the sticky stall_timeout, driven by one stall_event input. It is reused later for other stages.

Test Plan:
1. Reset then IF_to_ID_valid=1, bus=0x1C000000_02800421, both ready, EXE_allowin=1 → ID_to_EXE_valid=1 the next cycle with the same bus; ID_allowin stays 1; stall_cnt=0.
2. Load instruction with src_1_ready=0 for 3 cycles then 1 → ID_to_EXE_valid=0 for 3 cycles; ID_allowin=0 for 3 cycles; stall_cnt=3; issue on the 4th cycle.
3. Valid and ready with EXE_allowin=0 for 2 cycles → state S_BLOCK; ID_bus stable; stall_cnt unchanged; ID_allowin=0.
4. br_flush=1 while in S_WAIT with IF_to_ID_valid=1 → ID_to_EXE_valid=0 that cycle; next cycle ID_valid=0 and state S_EMPTY; new bus not latched.
5. TIMEOUT=4 with src_2_ready=0 held for 6 cycles → stall_timeout rises after the 4th stall edge and remains 1 after the ready returns; stall_cnt=6.
6. resetn pulled low mid-S_WAIT (between clock edges) → ID_to_EXE_valid=0, ID_allowin=1, stall_cnt=0 and stall_timeout=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/id_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_issue_ctrl_pkg
// Description : Shared widths and ID-stage FSM encodings for the ID issue
//               controller and its stall monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package id_issue_ctrl_pkg;

  localparam int IF_TO_ID_BUS_WD  = 64;
  localparam int ID_TO_EXE_BUS_WD = 64;
  localparam int STALL_CNT_WD     = 32;
  localparam int STALL_TIMEOUT    = 1024;

  // ID occupancy state; S_EMPTY is the only state in which ID holds nothing
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_WAIT  = 2'b01,
    S_BLOCK = 2'b10,
    S_ISSUE = 2'b11
  } id_state_t;

endpackage : id_issue_ctrl_pkg
`default_nettype wire

// File: rtl/id_issue_ctrl_stall_monitor.sv
`default_nettype none
// ============================================================================
// Module      : id_issue_ctrl_stall_monitor
// Description : Stall monitor - wrapping total stall-cycle counter, saturating
//               consecutive-stall counter and sticky watchdog flag, all driven
//               by a single stall_event strobe so other stages can reuse it.
// Revision    : 1.0 - initial release
// ============================================================================
module id_issue_ctrl_stall_monitor #(
  parameter int CNT_WD  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              stall_event,
  output logic [CNT_WD-1:0] stall_cnt,
  output logic              stall_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]     c_TIMEOUT  = CW'(TIMEOUT);
  localparam logic [CW-1:0]     c_CONS_ONE = CW'(1);
  localparam logic [CNT_WD-1:0] c_CNT_ONE  = CNT_WD'(1);

  logic [CNT_WD-1:0] r_stall_cnt;
  logic [CW-1:0]     r_consec;
  logic              r_timeout;
  logic [CW-1:0]     w_consec_nxt;

  // Consecutive count after this edge: saturates at TIMEOUT, clears on any non-stall edge
  always_comb begin
    w_consec_nxt = '0;
    if (stall_event) begin
      w_consec_nxt = (r_consec == c_TIMEOUT) ? r_consec : r_consec + c_CONS_ONE;
    end
  end

  // Counters and sticky flag; the flag rises on the same edge the count reaches TIMEOUT
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall_cnt <= '0;
      r_consec    <= '0;
      r_timeout   <= 1'b0;
    end else begin
      if (stall_event) begin
        r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
      end
      r_consec <= w_consec_nxt;
      if (w_consec_nxt == c_TIMEOUT) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign stall_cnt     = r_stall_cnt;
  assign stall_timeout = r_timeout;

endmodule : id_issue_ctrl_stall_monitor
`default_nettype wire

// File: rtl/id_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : id_issue_ctrl
// Description : ID-stage pipeline register and issue controller. Latches the
//               IF payload under valid/allowin, holds it while an operand is
//               not obtainable, and issues to EXE once both operands are ready
//               and EXE accepts. Exposes stall statistics and a watchdog flag.
// Revision    : 1.0 - initial release
// ============================================================================
module id_issue_ctrl
  import id_issue_ctrl_pkg::*;
#(
  parameter int BUS_WD  = IF_TO_ID_BUS_WD,
  parameter int CNT_WD  = STALL_CNT_WD,
  parameter int TIMEOUT = STALL_TIMEOUT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              IF_to_ID_valid,
  input  logic [BUS_WD-1:0] IF_to_ID_bus,
  output logic              ID_allowin,
  output logic [BUS_WD-1:0] ID_bus,
  input  logic              src_1_ready,
  input  logic              src_2_ready,
  input  logic              EXE_allowin,
  output logic              ID_to_EXE_valid,
  output logic [BUS_WD-1:0] ID_to_EXE_bus,
  input  logic              br_flush,
  output logic [CNT_WD-1:0] stall_cnt,
  output logic              stall_timeout
);

  id_state_t         r_state;
  logic [BUS_WD-1:0] r_id_bus;
  logic              w_id_valid;
  logic              w_ready_go;
  logic              w_next_valid;
  logic              w_load;
  logic              w_stall_event;

  // Handshake terms; ID occupancy is carried by the FSM itself (any non-empty state)
  always_comb begin
    w_id_valid      = (r_state != S_EMPTY);
    w_ready_go      = src_1_ready & src_2_ready;
    ID_allowin      = !w_id_valid | (w_ready_go & EXE_allowin);
    ID_to_EXE_valid = w_id_valid & w_ready_go & !br_flush;
    w_next_valid    = br_flush ? 1'b0 : (ID_allowin ? IF_to_ID_valid : w_id_valid);
    w_load          = ID_allowin & IF_to_ID_valid & !br_flush;
    // Only operand stalls count; EXE backpressure and flushed cycles do not
    w_stall_event   = w_id_valid & !w_ready_go & !br_flush;
  end

  // Occupancy FSM and payload register; flush kills ID and blocks any new accept
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_EMPTY;
      r_id_bus <= '0;
    end else begin
      if (w_load) begin
        r_id_bus <= IF_to_ID_bus;
      end
      if (!w_next_valid) begin
        r_state <= S_EMPTY;
      end else if (!w_ready_go) begin
        r_state <= S_WAIT;
      end else if (!EXE_allowin) begin
        r_state <= S_BLOCK;
      end else begin
        r_state <= S_ISSUE;
      end
    end
  end

  assign ID_bus        = r_id_bus;
  assign ID_to_EXE_bus = r_id_bus;

  id_issue_ctrl_stall_monitor #(
    .CNT_WD  (CNT_WD),
    .TIMEOUT (TIMEOUT)
  ) u_stall_monitor (
    .clk           (clk),
    .resetn        (resetn),
    .stall_event   (w_stall_event),
    .stall_cnt     (stall_cnt),
    .stall_timeout (stall_timeout)
  );

endmodule : id_issue_ctrl
`default_nettype wire
